atan2_sched: RTL

- Round-robin scheduler that shares one pipelined atan2 core (fixed latency, no valid or backpressure) between NCH requesting channels.
- Accepts one (x, y) sample per cycle from the granted channel and drives it into the core.
- Carries a channel tag through a delay line matched to the core latency.
- Returns each phase result tagged with its originating channel.
- Sits between per-channel front ends (e.g. I/Q demodulators) and the shared atan2 core.

---
 rtl/atan2_pkg.sv | 17 +
 rtl/atan2_tag_pipe.sv | 36 +++
 rtl/atan2_sched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/atan2_pkg.sv
// atan2_pkg: shared types for the atan2 scheduler and its tag delay line.
//   ch_t   - channel index, sized for the largest supported channel count (16)
//   tag_t  - {valid, ch} marker travelling alongside the shared core pipeline
//   STAT_W - width of the optional per-channel grant counters
package atan2_pkg;

    localparam int CH_W   = 4;
    localparam int STAT_W = 16;

    typedef logic [CH_W-1:0] ch_t;

    typedef struct packed {
        logic valid;
        ch_t  ch;
    } tag_t;

endpackage

// File: rtl/atan2_tag_pipe.sv
// atan2_tag_pipe: fixed-depth shift register of channel tags, used to keep a
// {valid, ch} marker in step with a shared core that has no valid of its own.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low clear; every stage becomes invalid
//   tag_in  - tag entering stage 0
//   tag_out - tag leaving the last stage, DEPTH cycles after entry
module atan2_tag_pipe
    import atan2_pkg::*;
#(
    parameter int DEPTH = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/atan2_sched.sv
// atan2_sched: round-robin scheduler sharing one fixed-latency atan2 core
// between NCH channels. One (x, y) sample per cycle is taken from the granted
// channel and presented to the core; a channel tag rides a matched delay line
// so every phase result comes back labelled with its source channel.
// Ports:
//   clk, reset          - clock; asynchronous active-low reset
//   en                  - grant enable (results in flight still drain)
//   req_valid/req_ready - per-channel handshake, req_ready one-hot
//   req_x, req_y        - packed per-channel signed samples, ch i at [i*WIDTH +: WIDTH]
//   core_x, core_y      - registered sample to the core
//   core_res            - core output, DELAY cycles after core_x/core_y
//   res_valid/res_ch/res_phase - registered tagged result
// Optional build macro ATAN2_SCHED_STATS_EN adds stat_sel / stat_cnt: one
// saturating 16-bit grant counter per channel, read back with one cycle latency.
module atan2_sched
    import atan2_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int DELAY = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [NCH-1:0]           req_valid,
    input  logic [NCH*WIDTH-1:0]     req_x,
    input  logic [NCH*WIDTH-1:0]     req_y,
    output logic [NCH-1:0]           req_ready,
    output logic [WIDTH-1:0]         core_x,
    output logic [WIDTH-1:0]         core_y,
    input  logic [WIDTH-1:0]         core_res,
`ifdef ATAN2_SCHED_STATS_EN
    input  logic [$clog2(NCH)-1:0]   stat_sel,
    output logic [STAT_W-1:0]        stat_cnt,
`endif
    output logic                     res_valid,
    output logic [$clog2(NCH)-1:0]   res_ch,
    output logic [WIDTH-1:0]         res_phase
);

    localparam int CHW = $clog2(NCH);

    logic                    grant_p0;
    logic [CHW-1:0]          gidx_p0;
    logic [CHW:0]            cand;
    logic [CHW-1:0]          ptr_q;
    logic signed [WIDTH-1:0] sel_x_p0;
    logic signed [WIDTH-1:0] sel_y_p0;
    tag_t                    tag_p0;
    tag_t                    tag_dly;

    // ---- stage p0: combinational round-robin arbitration ----
    // Search ptr+1, ptr+2, ... with wrap; the first valid channel wins.
    always_comb begin
        grant_p0  = 1'b0;
        gidx_p0   = '0;
        cand      = '0;
        req_ready = '0;
        if (en) begin
            for (int k = 1; k <= NCH; k++) begin
                cand = {1'b0, ptr_q} + (CHW+1)'(k);
                if (cand >= (CHW+1)'(NCH)) begin
                    cand = cand - (CHW+1)'(NCH);
                end
                if (!grant_p0 && req_valid[cand[CHW-1:0]]) begin
                    grant_p0 = 1'b1;
                    gidx_p0  = cand[CHW-1:0];
                end
            end
        end
        if (grant_p0) begin
            req_ready[gidx_p0] = 1'b1;
        end
    end

    assign sel_x_p0 = req_x[int'(gidx_p0)*WIDTH +: WIDTH];
    assign sel_y_p0 = req_y[int'(gidx_p0)*WIDTH +: WIDTH];

    always_comb begin
        tag_p0       = '0;
        tag_p0.valid = grant_p0;
        tag_p0.ch    = ch_t'(gidx_p0);
    end

    // ---- stage p1: core drive; idle cycles feed zeros to the core ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q  <= CHW'(NCH-1);
            core_x <= '0;
            core_y <= '0;
        end else if (grant_p0) begin
            ptr_q  <= gidx_p0;
            core_x <= sel_x_p0;
            core_y <= sel_y_p0;
        end else begin
            core_x <= '0;
            core_y <= '0;
        end
    end

    // One extra stage over DELAY accounts for the core_x register above.
    atan2_tag_pipe #(
        .DEPTH (DELAY + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (reset),
        .tag_in  (tag_p0),
        .tag_out (tag_dly)
    );

    // Tag bits above CHW are always zero for this channel count.
    logic unused_tag_bits;
    assign unused_tag_bits = &{1'b0, tag_dly.ch};

    // ---- stage p2: result register, aligned tag + core output ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_phase <= '0;
        end else begin
            res_valid <= tag_dly.valid;
            res_ch    <= tag_dly.ch[CHW-1:0];
            res_phase <= core_res;
        end
    end

`ifdef ATAN2_SCHED_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [STAT_W-1:0] cnt_q [NCH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            stat_cnt <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (grant_p0 && gidx_p0 == CHW'(i)) begin
                    cnt_q[i] <= sat_inc(cnt_q[i]);
                end
            end
            stat_cnt <= cnt_q[stat_sel];
        end
    end
`endif

endmodule
